// File: rtl/bcd_to_number_module.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_number_module
//  Description : Sequential six-digit BCD to 20-bit binary converter.
//                One multiply-by-10-and-add step per clock, most significant
//                digit first. A start pulse in IDLE captures all six digits.
//                Seven cycles later a one-cycle done pulse presents the binary
//                result together with an error flag. The error flag is raised
//                when any captured digit was above 9, and in that case the
//                result is forced to zero.
//
//  Ports       : clk_i          - system clock, rising edge
//                rst_i          - synchronous reset, active-high
//                start_i        - conversion request, sampled only in IDLE
//                dat_1_i..6_i   - BCD digits, 10^0 .. 10^5
//                number_data_o  - converted value, held until next completion
//                busy_o         - high while a conversion is in progress
//                done_o         - one-cycle completion pulse
//                err_o          - invalid-digit flag, held with number_data_o
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_number_module (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  dat_1_i,
    input  logic [3:0]  dat_2_i,
    input  logic [3:0]  dat_3_i,
    input  logic [3:0]  dat_4_i,
    input  logic [3:0]  dat_5_i,
    input  logic [3:0]  dat_6_i,
    output logic [19:0] number_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] C_LAST_DIGIT = 3'd5;
    localparam logic [3:0] C_MAX_DIGIT  = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [23:0]  r_digits;
    logic [23:0]  w_digits_nxt;
    logic [19:0]  r_acc;
    logic [19:0]  w_acc_nxt;
    logic [2:0]   r_cnt;
    logic [2:0]   w_cnt_nxt;
    logic         r_err;
    logic         w_err_nxt;

    logic [19:0]  r_number;
    logic [19:0]  w_number_nxt;
    logic         r_err_out;
    logic         w_err_out_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_any_bad;
    logic [19:0]  w_acc_x10;
    logic [19:0]  w_sum;

    // Any digit outside 0..9 marks the whole conversion as invalid.
    assign w_any_bad = (dat_1_i > C_MAX_DIGIT) | (dat_2_i > C_MAX_DIGIT) |
                       (dat_3_i > C_MAX_DIGIT) | (dat_4_i > C_MAX_DIGIT) |
                       (dat_5_i > C_MAX_DIGIT) | (dat_6_i > C_MAX_DIGIT);

    // acc*10 as (acc<<3)+(acc<<1). Working in 20 bits gives exactly the
    // low 20 bits of the 24-bit product, so the truncation matches. Valid
    // digits never reach the truncation point because 999999 < 2^20.
    assign w_acc_x10 = (r_acc << 3) + (r_acc << 1);
    assign w_sum     = w_acc_x10 + {16'd0, r_digits[23:20]};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_digits  <= 24'd0;
            r_acc     <= 20'd0;
            r_cnt     <= 3'd0;
            r_err     <= 1'b0;
            r_number  <= 20'd0;
            r_err_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_digits  <= w_digits_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_number  <= w_number_nxt;
            r_err_out <= w_err_out_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_digits_nxt  = r_digits;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_number_nxt  = r_number;
        w_err_out_nxt = r_err_out;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    // Most significant digit goes to the top nibble so it
                    // is consumed first.
                    w_digits_nxt = {dat_6_i, dat_5_i, dat_4_i,
                                    dat_3_i, dat_2_i, dat_1_i};
                    w_acc_nxt    = 20'd0;
                    w_cnt_nxt    = 3'd0;
                    w_err_nxt    = w_any_bad;
                    w_state_nxt  = S_CONV;
                end
            end

            S_CONV: begin
                // start_i is deliberately ignored here: no queueing.
                w_acc_nxt    = w_sum;
                w_digits_nxt = {r_digits[19:0], 4'd0};
                w_cnt_nxt    = r_cnt + 3'd1;
                if (r_cnt == C_LAST_DIGIT) begin
                    w_number_nxt  = r_err ? 20'd0 : w_sum;
                    w_err_out_nxt = r_err;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign number_data_o = r_number;
    assign err_o         = r_err_out;
    assign done_o        = r_done;
    assign busy_o        = (r_state == S_CONV);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_number_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_number_module
//  Description : Directed self-checking bench for bcd_to_number_module.
//                Inputs are driven 1 ns after the rising edge, and outputs
//                are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_number_module;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  dat_1_i, dat_2_i, dat_3_i, dat_4_i, dat_5_i, dat_6_i;
    logic [19:0] number_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_number_module u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .dat_1_i       (dat_1_i),
        .dat_2_i       (dat_2_i),
        .dat_3_i       (dat_3_i),
        .dat_4_i       (dat_4_i),
        .dat_5_i       (dat_5_i),
        .dat_6_i       (dat_6_i),
        .number_data_o (number_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_digits(input logic [23:0] d);
        dat_6_i = d[23:20];
        dat_5_i = d[19:16];
        dat_4_i = d[15:12];
        dat_3_i = d[11:8];
        dat_2_i = d[7:4];
        dat_1_i = d[3:0];
    endtask

    // mode 0: plain; mode 1: extra start in cycle 3; mode 2: digits wiggle.
    // Returns while in the done cycle (cycle 7) with start_i low.
    task automatic run_conv(input logic [23:0] digs, input logic [19:0] exp_val,
                            input logic exp_err, input int mode);
        set_digits(digs);
        start_i = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            check("busy_in_conv", 32'(busy_o), 32'd1);
            check("no_early_done", 32'(done_o), 32'd0);
            if (mode == 1 && k == 3) begin
                start_i = 1'b1;
                set_digits(24'h111111);
            end else begin
                start_i = 1'b0;
            end
            if (mode == 2)
                set_digits(24'($urandom));
            tick();
        end
        check("done_pulse", 32'(done_o), 32'd1);
        check("busy_low_done", 32'(busy_o), 32'd0);
        check("number_data", 32'(number_data_o), 32'(exp_val));
        check("err_flag", 32'(err_o), 32'(exp_err));
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        set_digits(24'h000000);
        tick();
        tick();
        check("rst_number", 32'(number_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;

        // Basic conversions
        run_conv(24'h123456, 20'h1E240, 1'b0, 0);
        tick();
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("hold_value", 32'(number_data_o), 32'd123456);

        run_conv(24'h999999, 20'hF423F, 1'b0, 0);
        tick();
        run_conv(24'h000000, 20'd0, 1'b0, 0);
        tick();

        // Invalid digit on hundreds, then a clean conversion clears err
        run_conv(24'h000A00, 20'd0, 1'b1, 0);
        tick();
        check("err_held", 32'(err_o), 32'd1);
        run_conv(24'h000042, 20'd42, 1'b0, 0);
        tick();

        // Start during CONV ignored; start in the done cycle runs back-to-back
        run_conv(24'h654321, 20'd654321, 1'b0, 1);
        run_conv(24'h000100, 20'd100, 1'b0, 0);
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("no_extra_done", 32'(done_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
        end
        check("b2b_hold", 32'(number_data_o), 32'd100);

        // Digit changes after acceptance must not matter
        run_conv(24'h024680, 20'd24680, 1'b0, 2);
        tick();

        // Reset in cycle 4 aborts; start in the reset cycle is ignored
        set_digits(24'h135791);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i   = 1'b1;
        start_i = 1'b1;
        set_digits(24'h222222);
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("abort_number", 32'(number_data_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_err", 32'(err_o), 32'd0);
        tick();
        check("abort_no_done", 32'(done_o), 32'd0);
        check("abort_idle", 32'(busy_o), 32'd0);
        run_conv(24'h000777, 20'd777, 1'b0, 0);
        tick();
        check("final_done_clear", 32'(done_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
